// File: rtl/ram_dma_ci.sv
// ram_dma_ci: custom-instruction block with a 512-word scratch SRAM and a burst DMA engine.
// Define RAM_DMA_WRITE_EN to compile in the SRAM-to-bus (write) path.
module ram_dma_ci #(
    parameter logic [7:0] customId = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result,
    output logic        requestTransaction,
    input  logic        transactionGranted,
    input  logic [31:0] addressDataIn,
    input  logic        endTransactionIn,
    input  logic        dataValidIn,
    input  logic        busErrorIn,
    output logic [31:0] addressDataOut,
    output logic [7:0]  burstSizeOut,
    output logic        readNotWriteOut,
    output logic        beginTransactionOut,
    output logic        endTransactionOut,
    output logic        dataValidOut
);

    typedef enum logic [3:0] {
        StIdle, StReqR, StInitR, StRead, StReqW, StInitW, StWrite, StWrEnd, StFinish
    } state_t;

    logic        w_active, w_we, w_sram_rd, w_cpu_we, w_ctl_wr, w_start_rd, w_go;
    logic        w_dma_we, w_short, w_unused;
    logic [2:0]  w_sel;
    logic [8:0]  w_addr;
    logic [31:0] w_reg_rd;
    logic [7:0]  w_burst_out;
    logic [9:0]  w_rem_dec;

    logic [31:0] r_mem [512];
    logic [31:0] r_rdata_a;
    logic        r_rd_pending;

    logic [31:0] r_cfg_bus;
    logic [8:0]  r_cfg_sram;
    logic [9:0]  r_cfg_size;
    logic [7:0]  r_cfg_burst;

    state_t      r_state;
    logic        r_busy, r_error, r_request, r_begin, r_rnw;
    logic [31:0] r_addr_out, r_bus_addr;
    logic [7:0]  r_burst_out, r_wburst;
    logic [8:0]  r_sram_addr, r_len;
    logic [9:0]  r_remaining;
`ifdef RAM_DMA_WRITE_EN
    logic [31:0] r_rdata_b;
    logic        r_dv_out, r_end_out;
    logic [8:0]  r_beats;
`endif

    assign w_active   = start && (ciN == customId);
    assign w_sel      = valueA[12:10];
    assign w_we       = valueA[9];
    assign w_addr     = valueA[8:0];
    assign w_unused   = ^valueA[31:13];
    assign w_sram_rd  = w_active && !w_we && (w_sel == 3'd0);
    assign w_cpu_we   = w_active && w_we && (w_sel == 3'd0);
    assign w_ctl_wr   = w_active && w_we && (w_sel == 3'd5) && (r_state == StIdle);
    assign w_start_rd = w_ctl_wr && valueB[0];
`ifdef RAM_DMA_WRITE_EN
    assign w_go       = w_ctl_wr && (valueB[0] || valueB[1]);
`else
    assign w_go       = w_start_rd;
`endif

    // Burst is cut short when fewer words remain than burst+1; then remaining <= 255.
    assign w_short     = ({2'b00, r_wburst} >= r_remaining);
    assign w_burst_out = w_short ? (r_remaining[7:0] - 8'd1) : r_wburst;
    assign w_rem_dec   = (r_remaining != 10'd0) ? (r_remaining - 10'd1) : r_remaining;
    assign w_dma_we    = (r_state == StRead) && dataValidIn;

    always_comb begin
        w_reg_rd = '0;
        case (w_sel)
            3'd1:    w_reg_rd = r_cfg_bus;
            3'd2:    w_reg_rd = {23'd0, r_cfg_sram};
            3'd3:    w_reg_rd = {22'd0, r_cfg_size};
            3'd4:    w_reg_rd = {24'd0, r_cfg_burst};
            3'd5:    w_reg_rd = {30'd0, r_error, r_busy};
            default: w_reg_rd = '0;
        endcase
    end

    assign done   = r_rd_pending || (w_active && !w_sram_rd);
    assign result = r_rd_pending ? r_rdata_a :
                    ((w_active && !w_we) ? w_reg_rd : 32'd0);

    // Dual-port SRAM: port A serves the CPU, port B the DMA engine.
    always_ff @(posedge clock) begin
        if (w_cpu_we) r_mem[w_addr] <= valueB;
        if (w_dma_we) r_mem[r_sram_addr] <= addressDataIn;
        r_rdata_a <= r_mem[w_addr];
`ifdef RAM_DMA_WRITE_EN
        r_rdata_b <= r_mem[r_sram_addr];
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_pending <= 1'b0;
            r_cfg_bus    <= '0;
            r_cfg_sram   <= '0;
            r_cfg_size   <= '0;
            r_cfg_burst  <= '0;
        end else begin
            r_rd_pending <= w_sram_rd;
            if (w_active && w_we) begin
                case (w_sel)
                    3'd1:    r_cfg_bus   <= valueB;
                    3'd2:    r_cfg_sram  <= valueB[8:0];
                    3'd3:    r_cfg_size  <= valueB[9:0];
                    3'd4:    r_cfg_burst <= valueB[7:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_busy      <= 1'b0;
            r_error     <= 1'b0;
            r_request   <= 1'b0;
            r_begin     <= 1'b0;
            r_rnw       <= 1'b0;
            r_addr_out  <= '0;
            r_burst_out <= '0;
            r_bus_addr  <= '0;
            r_sram_addr <= '0;
            r_remaining <= '0;
            r_wburst    <= '0;
            r_len       <= '0;
`ifdef RAM_DMA_WRITE_EN
            r_dv_out    <= 1'b0;
            r_end_out   <= 1'b0;
            r_beats     <= '0;
`endif
        end else if ((r_state != StIdle) && busErrorIn) begin
            r_state     <= StIdle;
            r_error     <= 1'b1;
            r_busy      <= 1'b0;
            r_request   <= 1'b0;
            r_begin     <= 1'b0;
            r_rnw       <= 1'b0;
            r_addr_out  <= '0;
            r_burst_out <= '0;
`ifdef RAM_DMA_WRITE_EN
            r_dv_out    <= 1'b0;
            r_end_out   <= 1'b0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_go) begin
                        r_busy      <= 1'b1;
                        r_error     <= 1'b0;
                        r_bus_addr  <= r_cfg_bus;
                        r_sram_addr <= r_cfg_sram;
                        r_remaining <= r_cfg_size;
                        r_wburst    <= r_cfg_burst;
                        if (r_cfg_size == 10'd0) begin
                            r_state <= StFinish;
                        end else begin
                            r_request <= 1'b1;
                            r_state   <= w_start_rd ? StReqR : StReqW;
                        end
                    end
                end
                StReqR, StReqW: begin
                    if (transactionGranted) begin
                        r_request   <= 1'b0;
                        r_begin     <= 1'b1;
                        r_rnw       <= (r_state == StReqR);
                        r_addr_out  <= r_bus_addr;
                        r_burst_out <= w_burst_out;
                        r_len       <= {1'b0, w_burst_out} + 9'd1;
                        r_state     <= (r_state == StReqR) ? StInitR : StInitW;
                    end
                end
                StInitR: begin
                    r_begin     <= 1'b0;
                    r_rnw       <= 1'b0;
                    r_addr_out  <= '0;
                    r_burst_out <= '0;
                    r_state     <= StRead;
                end
                StRead: begin
                    if (dataValidIn) begin
                        r_sram_addr <= r_sram_addr + 9'd1;
                        r_remaining <= w_rem_dec;
                    end
                    if (endTransactionIn) begin
                        if ((dataValidIn ? w_rem_dec : r_remaining) != 10'd0) begin
                            r_bus_addr <= r_bus_addr + {21'd0, r_len, 2'b00};
                            r_request  <= 1'b1;
                            r_state    <= StReqR;
                        end else begin
                            r_state <= StFinish;
                        end
                    end
                end
`ifdef RAM_DMA_WRITE_EN
                StInitW: begin
                    r_begin     <= 1'b0;
                    r_addr_out  <= '0;
                    r_burst_out <= '0;
                    r_dv_out    <= 1'b1;
                    r_beats     <= r_len - 9'd1;
                    r_sram_addr <= r_sram_addr + 9'd1;
                    r_remaining <= w_rem_dec;
                    r_state     <= StWrite;
                end
                StWrite: begin
                    if (r_beats != 9'd0) begin
                        r_beats     <= r_beats - 9'd1;
                        r_sram_addr <= r_sram_addr + 9'd1;
                        r_remaining <= w_rem_dec;
                    end else begin
                        r_dv_out  <= 1'b0;
                        r_end_out <= 1'b1;
                        r_state   <= StWrEnd;
                    end
                end
                StWrEnd: begin
                    r_end_out <= 1'b0;
                    if (r_remaining != 10'd0) begin
                        r_bus_addr <= r_bus_addr + {21'd0, r_len, 2'b00};
                        r_request  <= 1'b1;
                        r_state    <= StReqW;
                    end else begin
                        r_state <= StFinish;
                    end
                end
`endif
                StFinish: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign requestTransaction  = r_request;
    assign beginTransactionOut = r_begin;
    assign readNotWriteOut     = r_rnw;
    assign burstSizeOut        = r_burst_out;
`ifdef RAM_DMA_WRITE_EN
    // Port B read data is presented directly while streaming write beats.
    assign addressDataOut      = r_dv_out ? r_rdata_b : r_addr_out;
    assign dataValidOut        = r_dv_out;
    assign endTransactionOut   = r_end_out;
`else
    assign addressDataOut      = r_addr_out;
    assign dataValidOut        = 1'b0;
    assign endTransactionOut   = 1'b0;
`endif

endmodule

// File: tb/tb_ram_dma_ci.sv
// Bench for ram_dma_ci: directed scenarios plus randomized DMA transfers checked
// against a behavioural SRAM image and bus-burst model.
module tb_ram_dma_ci;
    localparam logic [7:0] CustomId = 8'h00;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  ciN = 8'd0;
    logic [31:0] valueA = 32'd0;
    logic [31:0] valueB = 32'd0;
    logic        done;
    logic [31:0] result;
    logic        requestTransaction;
    logic        transactionGranted = 1'b0;
    logic [31:0] addressDataIn = 32'd0;
    logic        endTransactionIn = 1'b0;
    logic        dataValidIn = 1'b0;
    logic        busErrorIn = 1'b0;
    logic [31:0] addressDataOut;
    logic [7:0]  burstSizeOut;
    logic        readNotWriteOut;
    logic        beginTransactionOut;
    logic        endTransactionOut;
    logic        dataValidOut;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model [512];

    always #5 clock = ~clock;

    ram_dma_ci #(.customId(CustomId)) dut (
        .clock               (clock),
        .reset               (reset),
        .start               (start),
        .ciN                 (ciN),
        .valueA              (valueA),
        .valueB              (valueB),
        .done                (done),
        .result              (result),
        .requestTransaction  (requestTransaction),
        .transactionGranted  (transactionGranted),
        .addressDataIn       (addressDataIn),
        .endTransactionIn    (endTransactionIn),
        .dataValidIn         (dataValidIn),
        .busErrorIn          (busErrorIn),
        .addressDataOut      (addressDataOut),
        .burstSizeOut        (burstSizeOut),
        .readNotWriteOut     (readNotWriteOut),
        .beginTransactionOut (beginTransactionOut),
        .endTransactionOut   (endTransactionOut),
        .dataValidOut        (dataValidOut)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] bus_flags();
        return {27'd0, requestTransaction, beginTransactionOut, readNotWriteOut,
                endTransactionOut, dataValidOut};
    endfunction

    task automatic ci_access(input logic wr, input logic [2:0] sel, input logic [8:0] addr,
                             input logic [31:0] data, output logic [31:0] rd);
        logic sram_rd;
        sram_rd = !wr && (sel == 3'd0);
        rd      = 32'd0;
        ciN     = CustomId;
        start   = 1'b1;
        valueA  = {19'd0, sel, wr, addr};
        valueB  = data;
        @(negedge clock);
        if (sram_rd) begin
            check_eq("sram_rd_not_done_early", 32'(done), 32'd0);
        end else begin
            check_eq("ci_done", 32'(done), 32'd1);
            rd = result;
        end
        tick();
        start  = 1'b0;
        valueA = 32'd0;
        valueB = 32'd0;
        if (sram_rd) begin
            @(negedge clock);
            check_eq("sram_rd_done", 32'(done), 32'd1);
            rd = result;
            tick();
        end
    endtask

    task automatic check_sram_range(input int base, input int len);
        logic [31:0] rd;
        for (int i = 0; i < len; i++) begin
            ci_access(1'b0, 3'd0, 9'((base + i) % 512), 32'd0, rd);
            check_eq("sram_readback", rd, model[(base + i) % 512]);
        end
    endtask

    task automatic wait_idle();
        logic [31:0] st;
        st = 32'd1;
        for (int n = 0; n < 10 && st[0]; n++) ci_access(1'b0, 3'd5, 9'd0, 32'd0, st);
        check_eq("status_idle", st, 32'd0);
    endtask

    // Acts as arbiter plus slave for one burst and checks the DMA's side of it.
    task automatic serve_burst(input logic rd_dir, input logic [31:0] exp_addr, input int len,
                               input int base, input logic fixed);
        int          n;
        logic [31:0] d;
        n = 0;
        while (!requestTransaction && n < 50) begin
            tick();
            n++;
        end
        check_eq("bus_request", 32'(requestTransaction), 32'd1);
        repeat ($urandom_range(0, 2)) begin
            tick();
            check_eq("request_held", 32'(requestTransaction), 32'd1);
        end
        transactionGranted = 1'b1;
        tick();
        transactionGranted = 1'b0;
        check_eq("init_flags", bus_flags(), {27'd0, 1'b0, 1'b1, rd_dir, 2'b00});
        check_eq("init_address", addressDataOut, exp_addr);
        check_eq("init_burst_size", 32'(burstSizeOut), 32'(len - 1));
        tick();
        check_eq("begin_one_cycle", 32'(beginTransactionOut), 32'd0);
        if (rd_dir) begin
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) tick();
                d = fixed ? 32'(33 + 10 * i) : $urandom;
                dataValidIn   = 1'b1;
                addressDataIn = d;
                model[(base + i) % 512] = d;
                tick();
                dataValidIn   = 1'b0;
                addressDataIn = 32'd0;
            end
            endTransactionIn = 1'b1;
            tick();
            endTransactionIn = 1'b0;
        end else begin
            for (int i = 0; i < len; i++) begin
                check_eq("write_beat_valid", 32'(dataValidOut), 32'd1);
                check_eq("write_beat_data", addressDataOut, model[(base + i) % 512]);
                tick();
            end
            check_eq("write_end_flags", bus_flags(), 32'b00010);
            tick();
            check_eq("write_end_one_cycle", 32'(endTransactionOut), 32'd0);
        end
    endtask

    task automatic dma_config(input logic [31:0] bus, input int sram, input int size,
                              input int burst);
        logic [31:0] tmp;
        ci_access(1'b1, 3'd1, 9'd0, bus, tmp);
        ci_access(1'b1, 3'd2, 9'd0, 32'(sram), tmp);
        ci_access(1'b1, 3'd3, 9'd0, 32'(size), tmp);
        ci_access(1'b1, 3'd4, 9'd0, 32'(burst), tmp);
    endtask

    task automatic dma_run(input logic rd_dir, input logic [31:0] bus, input int sram,
                           input int size, input int burst);
        logic [31:0] tmp, a;
        int          rem, len, s;
        dma_config(bus, sram, size, burst);
        ci_access(1'b1, 3'd5, 9'd0, rd_dir ? 32'd1 : 32'd2, tmp);
        rem = size;
        a   = bus;
        s   = sram;
        while (rem > 0) begin
            len = (burst + 1 < rem) ? burst + 1 : rem;
            serve_burst(rd_dir, a, len, s, 1'b0);
            a   = a + 32'(4 * len);
            s   = (s + len) % 512;
            rem = rem - len;
        end
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, d;
        logic        dir;
        int          sa, sz, bs;

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check_eq("reset_bus_flags", bus_flags(), 32'd0);
        check_eq("reset_address_out", addressDataOut, 32'd0);
        check_eq("reset_burst_out", 32'(burstSizeOut), 32'd0);
        check_eq("reset_done_result", {31'd0, done} | result, 32'd0);
        tick();
        ci_access(1'b0, 3'd5, 9'd0, 32'd0, rd);
        check_eq("reset_status", rd, 32'd0);
        ci_access(1'b0, 3'd1, 9'd0, 32'd0, rd);
        check_eq("reset_bus_addr_reg", rd, 32'd0);

        for (int i = 0; i < 512; i++) begin
            d = $urandom;
            model[i] = d;
            ci_access(1'b1, 3'd0, 9'(i), d, rd);
        end

        ci_access(1'b1, 3'd0, 9'd5, 32'hDEADBEEF, rd);
        model[5] = 32'hDEADBEEF;
        ci_access(1'b0, 3'd0, 9'd5, 32'd0, rd);
        check_eq("sram_addr5", rd, 32'hDEADBEEF);

        ci_access(1'b0, 3'd6, 9'd0, 32'd0, rd);
        check_eq("unused_select_result", rd, 32'd0);
        ci_access(1'b1, 3'd7, 9'd0, 32'hFFFF_FFFF, rd);
        check_eq("unused_select_write_result", rd, 32'd0);

        start  = 1'b1;
        ciN    = 8'h01;
        valueA = {19'd0, 3'd5, 1'b0, 9'd0};
        @(negedge clock);
        check_eq("foreign_ci_quiet", {31'd0, done} | result, 32'd0);
        tick();
        start  = 1'b0;
        valueA = 32'd0;

        dma_config(32'd55, 66, 5, 2);
        ci_access(1'b0, 3'd1, 9'd0, 32'd0, rd);
        check_eq("reg_bus_addr", rd, 32'd55);
        ci_access(1'b0, 3'd2, 9'd0, 32'd0, rd);
        check_eq("reg_sram_addr", rd, 32'd66);
        ci_access(1'b0, 3'd3, 9'd0, 32'd0, rd);
        check_eq("reg_block_size", rd, 32'd5);
        ci_access(1'b0, 3'd4, 9'd0, 32'd0, rd);
        check_eq("reg_burst_size", rd, 32'd2);

        ci_access(1'b1, 3'd5, 9'd0, 32'd1, rd);
        check_eq("request_after_start", 32'(requestTransaction), 32'd1);
        serve_burst(1'b1, 32'd55, 3, 66, 1'b1);
        serve_burst(1'b1, 32'd67, 2, 69, 1'b0);
        wait_idle();
        check_sram_range(66, 5);
        check_eq("plan_sram66", model[66], 32'd33);

        dma_config(32'd100, 200, 8, 3);
        ci_access(1'b1, 3'd5, 9'd0, 32'd1, rd);
        transactionGranted = 1'b1;
        tick();
        transactionGranted = 1'b0;
        tick();
        d             = $urandom;
        model[200]    = d;
        dataValidIn   = 1'b1;
        addressDataIn = d;
        tick();
        dataValidIn   = 1'b0;
        addressDataIn = 32'd0;
        busErrorIn    = 1'b1;
        tick();
        busErrorIn    = 1'b0;
        check_eq("buserr_flags", bus_flags(), 32'd0);
        check_eq("buserr_address_out", addressDataOut, 32'd0);
        tick();
        check_eq("buserr_flags_later", bus_flags(), 32'd0);
        ci_access(1'b0, 3'd5, 9'd0, 32'd0, rd);
        check_eq("buserr_status", rd, 32'd2);
        check_sram_range(200, 1);

        dma_config(32'h40, 10, 0, 1);
        ci_access(1'b1, 3'd5, 9'd0, 32'd1, rd);
        ci_access(1'b0, 3'd5, 9'd0, 32'd0, rd);
        check_eq("size0_busy_in_finish", rd, 32'd1);
        check_eq("size0_no_request", bus_flags(), 32'd0);
        wait_idle();

`ifdef RAM_DMA_WRITE_EN
        dma_run(1'b0, 32'h1000, 66, 3, 7);
`else
        dma_config(32'h1000, 66, 3, 7);
        ci_access(1'b1, 3'd5, 9'd0, 32'd2, rd);
        tick();
        check_eq("write_path_absent", bus_flags(), 32'd0);
        ci_access(1'b0, 3'd5, 9'd0, 32'd0, rd);
        check_eq("write_path_status", rd, 32'd0);
`endif

        for (int it = 0; it < 16; it++) begin
`ifdef RAM_DMA_WRITE_EN
            dir = 1'($urandom_range(0, 1));
`else
            dir = 1'b1;
`endif
            d  = $urandom & 32'hFFFF_FFFC;
            sa = $urandom_range(0, 511);
            sz = $urandom_range(1, 12);
            bs = $urandom_range(0, 4);
            dma_run(dir, d, sa, sz, bs);
            if (dir) check_sram_range(sa, sz);
            sa = $urandom_range(0, 511);
            d  = $urandom;
            model[sa] = d;
            ci_access(1'b1, 3'd0, 9'(sa), d, rd);
            check_sram_range(sa, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_dma_ci.md
# ram_dma_ci

Custom-instruction (CI) block giving the CPU a 512-word local scratch SRAM plus a DMA engine that moves blocks between that SRAM and the shared system bus in bursts. It sits on the CPU custom-instruction port; the CPU uses it for direct SRAM access and for configuring, starting and polling DMA. It is also a bus master behind the bus arbiter.

## Interface
- customId, 8'h00: CI number this block responds to.
- clock  in  1  system clock, rising edge.
- reset  in  1  reset, asynchronous, active-low.
- start  in  1  CI start strobe; valid only when ciN == customId.
- ciN  in  8  CI number.
- valueA  in  32  command: [8:0] SRAM address, [9] write enable, [12:10] target select.
- valueB  in  32  write data.
- done  out  1  CI completion strobe.
- result  out  32  CI read data; 0 when done=0.
- requestTransaction  out  1  bus request to arbiter.
- transactionGranted  in  1  arbiter grant, one-cycle pulse.
- addressDataIn  in  32  bus read data.
- endTransactionIn  in  1  slave ends burst.
- dataValidIn  in  1  addressDataIn valid.
- busErrorIn  in  1  bus error.
- addressDataOut  out  32  bus address during begin, write data during write.
- burstSizeOut  out  8  beats-1 of the current burst.
- readNotWriteOut  out  1  1 = bus read.
- beginTransactionOut  out  1  start-of-burst strobe.
- endTransactionOut  out  1  end-of-write-burst strobe.
- dataValidOut  out  1  addressDataOut carries write data.

## Operation
- CI active when start=1 and ciN=customId; otherwise done=0, result=0.
- valueA[12:10] select: 000 SRAM; 001 bus start address (32 b); 010 SRAM start address (9 b); 011 block size in words (10 b); 100 burst size (8 b, beats-1); 101 control/status. 110/111: done=1, result=0, no effect.
- valueA[9]=1 writes valueB to selected target; 0 reads it (result zero-extended).
- Control write: bit0=1 starts bus→SRAM transfer; bit1=1 starts SRAM→bus (see Configuration). Ignored while busy; bit0 wins if both set. Status read: bit0 busy, bit1 sticky bus error (cleared by next start).
- Config registers writable anytime; a running transfer uses internal working copies latched at start.
- FSM: IDLE → REQUEST_BUS_R/W (requestTransaction=1 until grant) → INIT_BURST_R/W (one cycle) → READ or WRITE → next burst or FINISH → IDLE.
- Burst length = min(burst+1, remaining words); burstSizeOut = length-1.
- READ: every cycle with dataValidIn=1, addressDataIn written to SRAM at working SRAM address; address +1 (wraps mod 512), remaining -1. On endTransactionIn: remaining>0 → bus address += 4·length, back to REQUEST_BUS_R; else FINISH.
- WRITE: streams length words from SRAM, one per cycle, dataValidOut=1; endTransactionOut=1 for one cycle after last word.
- busErrorIn in any non-IDLE state: set error, drop all bus outputs, go IDLE.
- Block size 0: start goes straight to FINISH, no bus activity.

## Timing
- Reset: all bus outputs 0, done=0, result=0, registers 0, FSM IDLE.
- All bus outputs are 0 outside their states; addressDataOut/burstSizeOut/readNotWriteOut/beginTransactionOut valid only in INIT_BURST.
- Register CI accesses and SRAM writes: done=1 same cycle as start (combinational).
- SRAM CI read: done=1 and data on result one cycle after start.
- CPU SRAM access and DMA share a dual-port SRAM: CPU port A, DMA port B; no stall.
- INIT_BURST entered the cycle after grant; READ/WRITE the cycle after.
- FINISH lasts one cycle; busy clears on FINISH → IDLE.

## Configuration
- RAM_DMA_WRITE_EN defined: SRAM→bus path (REQUEST_BUS_W/INIT_BURST_W/WRITE) compiled in.
- Undefined: control bit1 ignored; endTransactionOut and dataValidOut tied 0.

## Test plan
- Write SRAM addr 5 = 0xDEADBEEF, read back → done next cycle, result 0xDEADBEEF.
- Write regs 001=55, 010=66, 011=5, 100=2; read each back → identical values.
- Control=1 → requestTransaction=1 until grant; next cycle begin=1, readNotWrite=1, addressDataOut=55, burstSizeOut=2.
- Feed 33,43,53 with dataValidIn, then endTransactionIn → SRAM[66..68]=33,43,53; second burst at address 67, burstSizeOut=1; after end, status busy=0.
- busErrorIn during READ → outputs 0, status=0x2.
- With RAM_DMA_WRITE_EN, control=2, block 3 → begin with readNotWrite=0, three dataValidOut beats of SRAM data, endTransactionOut one cycle.
